// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with line-break support.
//
// A word is accepted from i_data when i_valid && o_ready. It is sent LSB
// first as: start(0), DATA_WIDTH data bits, optional parity, STOP_BITS
// stop bits (1), and one END bit period (1). o_done pulses at the end.
// All bit timing is driven by baud_clk, a one-clk-wide tick enable.
//
// Parameters:
//   DATA_WIDTH  payload bits per frame (5..9)
//   PARITY_MODE 0 none, 1 even, 2 odd
//   STOP_BITS   stop bits per frame (1..2)
// Ports:
//   clk        clock, all logic on rising edge
//   reset      synchronous active-high reset
//   baud_clk   bit-period tick enable
//   i_valid    i_data holds a word to send
//   i_data     payload word
//   o_ready    word accepted this cycle when i_valid is high
//   i_break    request line-break (line held low)
//   o_busy     frame or break in progress
//   o_done     one-clk pulse at the end of a frame or break
//   serial_out serial line, idle high
module uart_tx_cfg #(
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  baud_clk,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    input  logic                  i_break,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  serial_out
);

    generate
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
            $error("uart_tx_cfg: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, END, BREAK
    } state_t;

    state_t                state, state_d;
    logic [DATA_WIDTH-1:0] shreg, shreg_d;
    logic [3:0]            bit_cnt, bit_cnt_d;
    logic [1:0]            stop_cnt, stop_cnt_d;
    logic                  par_bit, par_bit_d;
    logic                  sout_d;
    logic                  done_d;

    assign o_ready = !reset && (state == IDLE) && !i_break;

    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        bit_cnt_d  = bit_cnt;
        stop_cnt_d = stop_cnt;
        par_bit_d  = par_bit;
        sout_d     = serial_out;
        done_d     = 1'b0;

        case (state)
            IDLE: begin
                // Break has priority over a pending word. A tick here is
                // ignored, so a tick coincident with acceptance is not used.
                if (i_break) begin
                    state_d = BREAK;
                end else if (i_valid) begin
                    state_d    = START;
                    shreg_d    = i_data;
                    // Parity fixed from the captured word; odd inverts.
                    par_bit_d  = (^i_data) ^ (PARITY_MODE == 2);
                    bit_cnt_d  = '0;
                    stop_cnt_d = '0;
                end
            end
            START: if (baud_clk) begin
                sout_d  = 1'b0;
                state_d = DATA;
            end
            DATA: if (baud_clk) begin
                sout_d    = shreg[0];
                shreg_d   = {1'b1, shreg[DATA_WIDTH-1:1]};
                bit_cnt_d = bit_cnt + 4'd1;
                if (bit_cnt == 4'(DATA_WIDTH - 1))
                    state_d = (PARITY_MODE != 0) ? PARITY : STOP;
            end
            PARITY: if (baud_clk) begin
                sout_d  = par_bit;
                state_d = STOP;
            end
            STOP: if (baud_clk) begin
                sout_d     = 1'b1;
                stop_cnt_d = stop_cnt + 2'd1;
                if (stop_cnt == 2'(STOP_BITS - 1))
                    state_d = END;
            end
            END: if (baud_clk) begin
                // Full high bit period before the next accept.
                sout_d  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            BREAK: if (baud_clk) begin
                if (i_break) begin
                    sout_d = 1'b0;
                end else begin
                    sout_d  = 1'b1;
                    state_d = END;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '1;
            bit_cnt    <= '0;
            stop_cnt   <= '0;
            par_bit    <= 1'b0;
            serial_out <= 1'b1;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            state      <= state_d;
            shreg      <= shreg_d;
            bit_cnt    <= bit_cnt_d;
            stop_cnt   <= stop_cnt_d;
            par_bit    <= par_bit_d;
            serial_out <= sout_d;
            o_busy     <= (state_d != IDLE);
            o_done     <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: an 8N1 instance and a 7-bit/odd/2-stop
// instance. Expected line bits are queued when a word is sent and popped
// on each baud tick.
module tb_uart_tx_cfg;

    logic       clk = 1'b0, reset = 1'b1, baud_clk = 1'b0;
    logic       va = 1'b0, ba = 1'b0;
    logic [7:0] da = '0;
    logic       ra, busya, donea, soa;
    logic       vb = 1'b0, bb = 1'b0;
    logic [6:0] db = '0;
    logic       rb, busyb, doneb, sob;

    int n_assert = 0;
    int n_fail   = 0;
    int sel      = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    uart_tx_cfg dut_a (
        .clk(clk), .reset(reset), .baud_clk(baud_clk), .i_valid(va), .i_data(da),
        .o_ready(ra), .i_break(ba), .o_busy(busya), .o_done(donea), .serial_out(soa)
    );

    uart_tx_cfg #(.DATA_WIDTH(7), .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .baud_clk(baud_clk), .i_valid(vb), .i_data(db),
        .o_ready(rb), .i_break(bb), .o_busy(busyb), .o_done(doneb), .serial_out(sob)
    );

    function automatic logic so();   return (sel != 0) ? sob   : soa;   endfunction
    function automatic logic busy(); return (sel != 0) ? busyb : busya; endfunction
    function automatic logic done(); return (sel != 0) ? doneb : donea; endfunction
    function automatic logic rdy();  return (sel != 0) ? rb    : ra;    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        baud_clk = 1'b1;
        step();
        baud_clk = 1'b0;
    endtask

    // Reference frame: start, data LSB first, parity, stops, END bit.
    task automatic push_frame(input logic [8:0] d);
        int dw, pm, sb;
        bit p;
        dw = (sel != 0) ? 7 : 8;
        pm = (sel != 0) ? 2 : 0;
        sb = (sel != 0) ? 2 : 1;
        p  = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            exp_q.push_back(d[i]);
            p ^= d[i];
        end
        if (pm != 0) exp_q.push_back((pm == 2) ? ~p : p);
        for (int i = 0; i < sb; i++) exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
    endtask

    task automatic send(input logic [8:0] d, input bit coincide, input string tag);
        if (sel != 0) begin vb = 1'b1; db = d[6:0]; end
        else          begin va = 1'b1; da = d[7:0]; end
        baud_clk = coincide;
        #1;
        chk({tag, "_ready"}, rdy(), 1);
        step();
        baud_clk = 1'b0;
        va = 1'b0;
        vb = 1'b0;
        chk({tag, "_busy0"}, busy(), 1);
        chk({tag, "_line0"}, so(), 1);
        push_frame(d);
    endtask

    // n ticks spaced gap clk apart (100 clk before tick index long_at).
    task automatic drain(input int n, input int gap, input int long_at, input string tag);
        logic prev;
        bit   e;
        int   g;
        for (int k = 0; k < n; k++) begin
            g = (k == long_at) ? 100 : gap;
            prev = so();
            repeat (g - 1) step();
            if (g > 1) begin
                chk($sformatf("%s_hold%0d", tag, k), so(), prev);
                chk($sformatf("%s_nodone%0d", tag, k), done(), 0);
            end
            tick();
            e = exp_q.pop_front();
            chk($sformatf("%s_bit%0d", tag, k), so(), e);
            chk($sformatf("%s_busy%0d", tag, k), busy(), exp_q.size() != 0);
            chk($sformatf("%s_done%0d", tag, k), done(), exp_q.size() == 0);
        end
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        step();
        step();
        chk("rst_line", soa, 1);
        chk("rst_busy", busya, 0);
        chk("rst_done", donea, 0);
        chk("rst_ready", ra, 0);
        chk("rst_line_b", sob, 1);
        reset = 1'b0;

        // Tick while idle leaves the line high
        sel = 0;
        tick();
        chk("idle_line", soa, 1);
        chk("idle_busy", busya, 0);
        chk("idle_done", donea, 0);

        // 8N1 0xA5, tick every 16 clk
        send(9'h0A5, 1'b0, "a5");
        drain(11, 16, -1, "a5");

        // Back-to-back with i_valid held; data change mid-frame ignored
        va = 1'b1;
        da = 8'h01;
        #1;
        chk("b2b_ready1", ra, 1);
        step();
        da = 8'h02;
        chk("b2b_busy1", busya, 1);
        push_frame(9'h001);
        drain(11, 4, -1, "b2b1");
        chk("b2b_ready2", ra, 1);
        step();
        va = 1'b0;
        chk("b2b_busy2", busya, 1);
        push_frame(9'h002);
        drain(11, 4, -1, "b2b2");

        // Break wins over a pending word
        ba = 1'b1;
        va = 1'b1;
        da = 8'hFF;
        #1;
        chk("brk_ready", ra, 0);
        step();
        va = 1'b0;
        chk("brk_busy", busya, 1);
        chk("brk_line", soa, 1);
        repeat (5) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        drain(5, 3, -1, "brk");
        ba = 1'b0;
        drain(2, 3, -1, "brk_end");
        tick();
        chk("brk_noword_line", soa, 1);
        chk("brk_noword_busy", busya, 0);

        // Reset after data bit 3 of 0x3C, then immediate fresh word
        send(9'h03C, 1'b0, "r3c");
        drain(5, 2, -1, "r3c");
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", ra, 0);
        step();
        chk("mid_rst_line", soa, 1);
        chk("mid_rst_busy", busya, 0);
        chk("mid_rst_done", donea, 0);
        exp_q.delete();
        reset = 1'b0;
        send(9'h081, 1'b0, "r81");
        drain(11, 2, -1, "r81");

        // Tick coincident with accept, and a 100-clk stall mid-frame
        send(9'h0C3, 1'b1, "coin");
        drain(11, 3, 5, "coin");

        // 7 data bits, odd parity, 2 stop bits
        sel = 1;
        send(9'h055, 1'b0, "p7");
        drain(12, 5, -1, "p7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
